md5_round_core: RTL and testbench
=================================

Name: md5_round_core

Overview:
- Iterative MD5 compression engine for the Hash Generator; the direct consumer of the 64-entry K-constant LUT (LUT_K).
- Drives the LUT address each step and consumes the returned 32-bit constant.
- Runs one MD5 step per clock over a pre-padded 512-bit block and accumulates the 128-bit chaining value across blocks.
- Upstream padding/framing logic supplies blocks; downstream logic reads the digest.

Parameters:
- none; the block is fixed to MD5 (32-bit words, 64 steps, 512-bit block).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to compress the block on msg; accepted only when ready=1.
- chain  in  1  sampled with start: 0 = begin a new message from the IV; 1 = continue from the current digest.
- msg  in  512  block words; msg[32*i+31:32*i] = M[i], i=0..15, already in little-endian word form.
- k_addr  out  6  step index to LUT_K.addr.
- k_data  in  32  constant from LUT_K.out; combinational, valid in the same cycle as k_addr.
- ready  out  1  high in IDLE; start is accepted when ready=1.
- done  out  1  one-cycle pulse when digest holds the result of the accepted block.
- digest  out  128  {A,B,C,D} raw chaining words; byte reordering for hex output happens outside this block.

Behaviour:
- States: IDLE, RUN, FINISH.
- Reset (async): state=IDLE, ready=1, done=0, k_addr=0, digest=0, step counter=0, working regs a/b/c/d=0.
- IDLE:
  - When start=1 at edge E0, the block registers msg.
  - Chain select: chain=0 loads H from IV (A=67452301, B=efcdab89, C=98badcfe, D=10325476); chain=1 takes H from digest.
  - a/b/c/d are loaded from the selected H; step=0; state→RUN; ready→0.
  - start=0 leaves everything unchanged.
- RUN:
  - k_addr = step (register output).
  - Step i completes at edge E(i+1): F' = f + a + k_data + M[g]; a←d, d←c, c←b, b←b + rotl(F', s). All adds are mod 2^32.
  - Round functions by i/16:
    - 0: f=(b&c)|(~b&d), g=i.
    - 1: f=(d&b)|(~d&c), g=(5i+1) mod 16.
    - 2: f=b^c^d, g=(3i+5) mod 16.
    - 3: f=c^(b|~d), g=7i mod 16.
  - Shift s = table[i/16][i mod 4]:
    - round 0: {7,12,17,22}
    - round 1: {5,9,14,20}
    - round 2: {4,11,16,23}
    - round 3: {6,10,15,21}
  - After step 63 (edge E64): step wraps to 0; state→FINISH.
- FINISH (edge E65):
  - digest ← {H.A+a, H.B+b, H.C+c, H.D+d} (each mod 2^32).
  - done=1 for exactly the cycle after E65; state→IDLE; ready=1 from the same cycle.
- Latency: start sampled at E0 → done high after E65 (65 cycles).
- Back-to-back: start may be asserted in the done cycle; it is accepted at E66 with no bubble. chain=1 then uses the just-written digest.
- start while ready=0 is ignored; no queueing.
- msg and chain changes after acceptance have no effect; msg is captured at E0.
- digest holds its value until the next FINISH or reset. It is not cleared at start.
- Reset mid-RUN/FINISH: immediate return to reset values; the partial block is discarded and no done pulse is generated.
- k_addr stays 0 outside RUN.

Test Plan:
- "abc" block (M0=0x80636261, M14=0x00000018, others 0), chain=0, real LUT_K attached → done exactly 65 cycles after start accepted; digest = 98500190_b04fd23c_7d3f96d6_727fe128 (MD5 900150983cd24fb0d6963f7d28e17f72).
- Empty-string block (M0=0x00000080, others 0), chain=0 → digest = d98c1dd4_04b2008f_980980e9_7e42f8ec.
- k_addr trace during RUN → 0,1,…,63 on consecutive cycles. A bench golden K table is compared against LUT_K for every address and must match all 64 entries.
- Two-block message (56-byte 'a' string padded into 2 blocks: block 1 chain=0, block 2 chain=1, second start asserted in the done cycle) → second done 65 cycles later; digest equals the reference-model MD5 of the string.
- start pulsed during RUN with different msg → ignored; result identical to the uninterrupted run; exactly one done pulse.
- rst asserted at step 30 → ready=1, done=0, digest=0, k_addr=0 asynchronously. A following "abc" run with chain=0 gives the correct digest.

Source files
------------

// File: rtl/md5_round_core_if.sv
// Bundle between the MD5 round core, its block source and the LUT_K constant table.
interface md5_round_core_if;
  logic         start;
  logic         chain;
  logic [511:0] msg;
  logic [5:0]   k_addr;
  logic [31:0]  k_data;
  logic         ready;
  logic         done;
  logic [127:0] digest;

  modport master (
    output start, chain, msg, k_data,
    input  k_addr, ready, done, digest
  );

  modport slave (
    input  start, chain, msg, k_data,
    output k_addr, ready, done, digest
  );
endinterface

// File: rtl/md5_round_core.sv
// Iterative MD5 compression: one step per clock over a 512-bit block, with the
// 128-bit chaining value accumulated in digest across blocks.
module md5_round_core (
  input logic             clk,
  input logic             rst,
  md5_round_core_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;

  localparam logic [127:0] Iv = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

  logic [1:0]   state_q, state_d;
  logic [5:0]   step_q, step_d;
  logic [511:0] msg_q, msg_d;
  logic [127:0] h_q, h_d;
  logic [31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [127:0] digest_q, digest_d;
  logic         done_q, done_d;

  logic [1:0]   round;
  logic [3:0]   g;
  logic [4:0]   s;
  logic [31:0]  f, m_g, f_sum, rot;

  assign round = step_q[5:4];

  // Round function and message word index; g arithmetic is naturally mod 16.
  always_comb begin
    f = '0;
    g = '0;
    case (round)
      2'd0: begin
        f = (b_q & c_q) | (~b_q & d_q);
        g = step_q[3:0];
      end
      2'd1: begin
        f = (d_q & b_q) | (~d_q & c_q);
        g = step_q[3:0] * 4'd5 + 4'd1;
      end
      2'd2: begin
        f = b_q ^ c_q ^ d_q;
        g = step_q[3:0] * 4'd3 + 4'd5;
      end
      default: begin
        f = c_q ^ (b_q | ~d_q);
        g = step_q[3:0] * 4'd7;
      end
    endcase
  end

  always_comb begin
    s = 5'd0;
    case ({round, step_q[1:0]})
      4'h0: s = 5'd7;
      4'h1: s = 5'd12;
      4'h2: s = 5'd17;
      4'h3: s = 5'd22;
      4'h4: s = 5'd5;
      4'h5: s = 5'd9;
      4'h6: s = 5'd14;
      4'h7: s = 5'd20;
      4'h8: s = 5'd4;
      4'h9: s = 5'd11;
      4'ha: s = 5'd16;
      4'hb: s = 5'd23;
      4'hc: s = 5'd6;
      4'hd: s = 5'd10;
      4'he: s = 5'd15;
      default: s = 5'd21;
    endcase
  end

  assign m_g   = msg_q[{g, 5'b00000} +: 32];
  assign f_sum = f + a_q + bus.k_data + m_g;
  // s is never 0, so the right shift is always in 1..28.
  assign rot   = (f_sum << s) | (f_sum >> (6'd32 - {1'b0, s}));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    msg_d    = msg_q;
    h_d      = h_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    digest_d = digest_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          msg_d   = bus.msg;
          h_d     = bus.chain ? digest_q : Iv;
          a_d     = h_d[127:96];
          b_d     = h_d[95:64];
          c_d     = h_d[63:32];
          d_d     = h_d[31:0];
          step_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d    = d_q;
        d_d    = c_q;
        c_d    = b_q;
        b_d    = b_q + rot;
        step_d = step_q + 6'd1;
        if (step_q == 6'd63) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        digest_d = {h_q[127:96] + a_q, h_q[95:64] + b_q, h_q[63:32] + c_q, h_q[31:0] + d_q};
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      step_q   <= '0;
      msg_q    <= '0;
      h_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      msg_q    <= msg_d;
      h_q      <= h_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      digest_q <= digest_d;
      done_q   <= done_d;
    end
  end

  // step_q is 0 outside RUN, so it doubles as the LUT address.
  assign bus.k_addr = step_q;
  assign bus.ready  = (state_q == StIdle);
  assign bus.done   = done_q;
  assign bus.digest = digest_q;

endmodule

// File: tb/tb_md5_round_core.sv
// Directed bench for md5_round_core: stands in for LUT_K and checks digests,
// latency, k_addr sequencing, back-to-back chaining, ignored starts and async reset.
module tb_md5_round_core;

  localparam logic [31:0] KTab [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam int ShiftTab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
  localparam logic [127:0] Iv       = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [127:0] AbcDig   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
  localparam logic [127:0] EmptyDig = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;

  typedef struct {
    logic         chain;
    logic [511:0] msg;
    logic [127:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  md5_round_core_if bus ();

  md5_round_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.k_data = KTab[bus.k_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Textbook MD5 compression of one block from chaining value h.
  function automatic logic [127:0] md5_ref(input logic [127:0] h, input logic [511:0] m);
    logic [31:0] a, b, c, d, f, t, tmp;
    int          g, s;
    a = h[127:96];
    b = h[95:64];
    c = h[63:32];
    d = h[31:0];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      s   = ShiftTab[(i / 16) * 4 + (i % 4)];
      t   = f + a + KTab[i] + m[32 * g +: 32];
      tmp = d;
      d   = c;
      c   = b;
      b   = b + ((t << s) | (t >> (32 - s)));
      a   = tmp;
    end
    return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Called #1 after an edge with ready=1; returns #1 after the done edge.
  task automatic run_block(input logic ch, input logic [511:0] m, output int lat,
                           output int kbad);
    bus.start = 1'b1;
    bus.chain = ch;
    bus.msg   = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.msg   = ~m;
    bus.chain = ~ch;
    lat  = 0;
    kbad = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (lat < 64 && bus.k_addr !== 6'(lat)) kbad++;
      @(posedge clk); #1;
      lat++;
      if (lat == 64 && bus.k_addr !== 6'd0) kbad++;
    end
  endtask

  logic [511:0] abc_msg, empty_msg, blk1, blk2;
  logic [127:0] exp1;
  vec_t         vecs [3];
  int           lat, kbad, dones, first;

  initial begin
    abc_msg            = '0;
    abc_msg[31:0]      = 32'h80636261;
    abc_msg[479:448]   = 32'h00000018;
    empty_msg          = '0;
    empty_msg[31:0]    = 32'h00000080;
    blk1               = '0;
    for (int i = 0; i < 14; i++) blk1[32 * i +: 32] = 32'h61616161;
    blk1[479:448]      = 32'h00000080;
    blk2               = '0;
    blk2[479:448]      = 32'h000001c0;

    vecs[0] = '{chain: 1'b0, msg: abc_msg,   exp: AbcDig};
    vecs[1] = '{chain: 1'b0, msg: empty_msg, exp: EmptyDig};
    vecs[2] = '{chain: 1'b1, msg: abc_msg,   exp: md5_ref(EmptyDig, abc_msg)};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.chain = 1'b0;
    bus.msg   = '0;
    #2;
    check("reset ready", bus.ready, 1);
    check("reset done", bus.done, 0);
    check("reset digest", bus.digest, 0);
    check("reset k_addr", bus.k_addr, 0);
    #20 rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 3; v++) begin
      run_block(vecs[v].chain, vecs[v].msg, lat, kbad);
      check($sformatf("vec%0d latency", v), lat, 65);
      check($sformatf("vec%0d k_addr trace", v), kbad, 0);
      check($sformatf("vec%0d digest", v), bus.digest, vecs[v].exp);
      check($sformatf("vec%0d ready in done cycle", v), bus.ready, 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d done width", v), bus.done, 0);
    end

    // Two-block message, second start in the done cycle of the first.
    exp1 = md5_ref(Iv, blk1);
    run_block(1'b0, blk1, lat, kbad);
    check("two-block blk1 latency", lat, 65);
    check("two-block blk1 digest", bus.digest, exp1);
    run_block(1'b1, blk2, lat, kbad);
    check("two-block blk2 latency", lat, 65);
    check("two-block blk2 digest", bus.digest, md5_ref(exp1, blk2));
    @(posedge clk); #1;

    // start pulsed mid-run with a different block must be ignored.
    bus.start = 1'b1;
    bus.chain = 1'b0;
    bus.msg   = abc_msg;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("accept drops ready", bus.ready, 0);
    dones = 0;
    first = 0;
    for (int n = 1; n <= 80; n++) begin
      if (n == 10) begin
        bus.start = 1'b1;
        bus.msg   = empty_msg;
        bus.chain = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        dones++;
        if (first == 0) begin
          first = n;
          check("ignored start digest", bus.digest, AbcDig);
        end
      end
    end
    check("ignored start done count", dones, 1);
    check("ignored start latency", first, 65);

    // Async reset at step 30, then a fresh abc run.
    bus.start = 1'b1;
    bus.chain = 1'b0;
    bus.msg   = abc_msg;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("k_addr at step 30", bus.k_addr, 30);
    rst = 1'b1;
    #1;
    check("mid-run reset ready", bus.ready, 1);
    check("mid-run reset done", bus.done, 0);
    check("mid-run reset digest", bus.digest, 0);
    check("mid-run reset k_addr", bus.k_addr, 0);
    #2 rst = 1'b0;
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    check("no done after reset", dones, 0);
    run_block(1'b0, abc_msg, lat, kbad);
    check("post-reset latency", lat, 65);
    check("post-reset k_addr trace", kbad, 0);
    check("post-reset digest", bus.digest, AbcDig);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
